rx_frame_reader: RTL
====================

// Module: rx_frame_reader
// PURPOSE
//  Drains complete frames from the RX frame FIFO read port and presents them as a byte stream
//  with valid/ready backpressure and sof/eof markers to the host-side consumer.
//  Sits directly downstream of the RX state machine. Supports per-frame drop and replay
//  via the FIFO read-pointer rewind port, and counts delivered, dropped and errored frames.
// PARAMETERS
//  FIFO_DEPTH  12    FIFO address width; must match the RX state machine FIFO_DEPTH
//  MAX_FRAME   1518  bytes after which a frame with no end marker is declared malformed
// PORTS
//  clock            in   1           read-side clock (FIFO data_out_clock)
//  reset            in   1           asynchronous, active-high
//  fifo_data        in   8           FIFO read data
//  fifo_start       in   1           FIFO read start-of-frame flag
//  fifo_end         in   1           FIFO read end-of-frame flag
//  fifo_address     in   FIFO_DEPTH  FIFO current read address
//  data_available   in   1           at least one complete frame is committed in the FIFO
//  fifo_rd_en       out  1           FIFO read enable (data_out_enable)
//  fifo_rewind      out  1           FIFO read-pointer load strobe (data_out_reset)
//  fifo_rewind_addr out  FIFO_DEPTH  read-pointer load value (data_out_reset_address)
//  m_data           out  8           stream byte
//  m_valid          out  1           m_data/m_sof/m_eof valid
//  m_ready          in   1           consumer accepts the byte on a clock edge with m_valid=1
//  m_sof / m_eof    out  1           first / last byte of the frame
//  m_drop           in   1           pulse: discard the rest of the current frame
//  m_replay         in   1           pulse: restart the current frame from its first byte
//  frame_ok_count   out  16          frames fully delivered (wraps at 16'hFFFF)
//  frame_drop_count out  16          frames dropped by m_drop or by an error (wraps)
//  frame_error      out  1           one-cycle pulse on a malformed frame
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; skid buffer empty; counters 0.
//  - FIFO read latency: fifo_rd_en=1 at edge N gives fifo_data, fifo_start, fifo_end valid
//    in cycle N+1.
//  - 2-entry skid buffer. fifo_rd_en is asserted only if buffered + in-flight bytes < 2, so
//    a byte is never lost when m_ready is deasserted. m_data is driven from the skid head.
//  - Streaming throughput: 1 byte/cycle when m_ready is held high.
//  - States:
//    IDLE: fifo_rd_en=0. When data_available=1, latch start_addr<=fifo_address and go to READ.
//    READ: issue reads and push returned bytes into the skid buffer; len counts bytes read.
//      - The first returned byte must have fifo_start=1. Otherwise: frame_error, go to DISCARD.
//      - A returned byte with fifo_end=1 stops further reads; go to DRAIN.
//      - If len reaches MAX_FRAME without fifo_end: frame_error, go to DISCARD.
//    DRAIN: no reads. When the m_eof byte is accepted: frame_ok_count+1, go to IDLE.
//    DISCARD: skid buffer flushed; m_valid=0. Keep reading and discarding bytes until
//      fifo_end is returned, then go to IDLE. If fifo_end was already read, go to IDLE next
//      cycle. On entry: frame_drop_count+1.
//    REPLAY: one cycle with fifo_rewind=1 and fifo_rewind_addr=start_addr; skid buffer and
//      in-flight byte flushed; len=0; then go to READ.
//  - m_drop in READ/DRAIN: go to DISCARD. m_replay in READ/DRAIN: go to REPLAY.
//    If both are asserted in the same cycle, m_drop wins. Both are ignored in IDLE, DISCARD
//    and REPLAY.
//  - m_sof=1 only on the byte tagged fifo_start. m_eof=1 only on the byte tagged fifo_end.
//  - A drop/replay on the same edge that the eof byte is accepted is ignored: the frame
//    counts as delivered.
//  - data_available falling mid-frame does not affect the current frame.
//  - Asynchronous reset mid-frame returns to IDLE with no rewind. FIFO recovery is owned by
//    the FIFO reset.
// TESTING
//  - 64-byte frame, m_ready=1: 64 consecutive m_valid beats, m_sof on beat 0, m_eof on
//    beat 63. frame_ok_count=1.
//  - Same frame, m_ready toggling 1/0 every cycle: byte order 0..63 intact, no duplicates.
//    fifo_rd_en never causes more than 2 bytes outstanding.
//  - m_replay after byte 10: fifo_rewind pulses once with start_addr. Stream restarts at
//    byte 0 with m_sof, full 64 bytes follow. frame_ok_count=1.
//  - m_drop after byte 20, then a second 64-byte frame: rest of frame 1 suppressed.
//    frame_drop_count=1, frame 2 delivered intact. frame_ok_count=1.
//  - First FIFO byte without start flag: frame_error pulse, bytes discarded through the end
//    flag, next frame delivered normally.
//  - 1600 bytes with no end flag and MAX_FRAME=1518: frame_error after byte 1518,
//    frame_drop_count=1. Reset asserted mid-frame: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/rx_frame_reader.sv
// Drains committed frames from the RX frame FIFO into a valid/ready byte stream with
// sof/eof markers, per-frame drop/replay through the read-pointer rewind port, and frame stats.
module rx_frame_reader #(
   parameter int unsigned FIFO_DEPTH = 12,
   parameter int unsigned MAX_FRAME  = 1518
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            fifo_data,
   input  logic                  fifo_start,
   input  logic                  fifo_end,
   input  logic [FIFO_DEPTH-1:0] fifo_address,
   input  logic                  data_available,
   output logic                  fifo_rd_en,
   output logic                  fifo_rewind,
   output logic [FIFO_DEPTH-1:0] fifo_rewind_addr,
   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eof,
   input  logic                  m_drop,
   input  logic                  m_replay,
   output logic [15:0]           frame_ok_count,
   output logic [15:0]           frame_drop_count,
   output logic                  frame_error
);

   localparam int unsigned LEN_W = $clog2(MAX_FRAME + 1);
   localparam int unsigned ENT_W = 10;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {IDLE, READ, DRAIN, DISCARD, REPLAY} state_t;

   state_t                state, state_n;
   logic [FIFO_DEPTH-1:0] start_addr, start_addr_n;
   logic [LEN_W-1:0]      len, len_n, len_inc;
   logic                  end_seen, end_seen_n;
   logic                  in_flight;
   // Skid entries hold {sof, eof, data}; skid0 is the head driving the stream.
   logic [ENT_W-1:0]      skid0, skid0_n, skid1, skid1_n, entry_in;
   logic [1:0]            count, count_n;
   logic [CNT_W-1:0]      ok_n, drop_n;
   logic                  frame_error_n;
   logic                  rd_en_c;
   logic                  pop, push, flush, err, ret_end, room;
   logic [2:0]            occ;

   assign m_valid          = (count != 2'd0);
   assign m_data           = skid0[7:0];
   assign m_sof            = m_valid & skid0[9];
   assign m_eof            = m_valid & skid0[8];
   assign fifo_rd_en       = rd_en_c;
   assign fifo_rewind      = (state == REPLAY);
   assign fifo_rewind_addr = start_addr;
   assign entry_in         = {fifo_start, fifo_end, fifo_data};

   // Next-state, read issue, skid buffer and statistics
   always_comb begin
      state_n       = state;
      start_addr_n  = start_addr;
      len_n         = len;
      end_seen_n    = end_seen;
      skid0_n       = skid0;
      skid1_n       = skid1;
      count_n       = count;
      ok_n          = frame_ok_count;
      drop_n        = frame_drop_count;
      frame_error_n = 1'b0;
      rd_en_c       = 1'b0;
      push          = 1'b0;
      flush         = 1'b0;
      err           = 1'b0;
      pop           = m_valid & m_ready;
      ret_end       = in_flight & fifo_end;
      len_inc       = len + LEN_W'(1);
      // Occupancy after this edge counting the returning byte; the pop frees a slot now.
      occ           = 3'(count) + 3'(in_flight) - 3'(pop);
      room          = (occ < 3'd2);

      unique case (state)
         IDLE: begin
            if (data_available) begin
               state_n      = READ;
               start_addr_n = fifo_address;
               len_n        = '0;
               end_seen_n   = 1'b0;
            end
         end
         READ: begin
            if (in_flight) begin
               len_n      = len_inc;
               end_seen_n = end_seen | fifo_end;
            end
            if (m_drop) begin
               state_n = DISCARD;
            end else if (m_replay) begin
               state_n = REPLAY;
            end else if (in_flight) begin
               if ((len == '0) && !fifo_start) begin
                  err     = 1'b1;
                  state_n = DISCARD;
               end else if (fifo_end) begin
                  push    = 1'b1;
                  state_n = DRAIN;
               end else if (len_inc == LEN_W'(MAX_FRAME)) begin
                  err     = 1'b1;
                  state_n = DISCARD;
               end else begin
                  push = 1'b1;
               end
            end
            // The end flag is seen combinationally so no byte past the frame is ever read.
            rd_en_c = room && !ret_end && (state_n != REPLAY);
         end
         DRAIN: begin
            if (pop && skid0[8]) begin
               state_n = IDLE;
               ok_n    = frame_ok_count + CNT_W'(1);
            end else if (m_drop) begin
               state_n = DISCARD;
            end else if (m_replay) begin
               state_n = REPLAY;
            end
         end
         DISCARD: begin
            if (end_seen || ret_end) begin
               state_n = IDLE;
            end else begin
               rd_en_c = 1'b1;
            end
         end
         REPLAY: begin
            state_n    = READ;
            len_n      = '0;
            end_seen_n = 1'b0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if ((state_n == DISCARD) && (state != DISCARD)) begin
         drop_n = frame_drop_count + CNT_W'(1);
      end
      flush         = (state_n == DISCARD) || (state_n == REPLAY);
      frame_error_n = err;

      if (flush) begin
         count_n = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) skid0_n = entry_in;
               else               skid1_n = entry_in;
               count_n = count + 2'd1;
            end
            2'b01: begin
               skid0_n = skid1;
               count_n = count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  skid0_n = entry_in;
               end else begin
                  skid0_n = skid1;
                  skid1_n = entry_in;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         start_addr       <= '0;
         len              <= '0;
         end_seen         <= 1'b0;
         in_flight        <= 1'b0;
         skid0            <= '0;
         skid1            <= '0;
         count            <= 2'd0;
         frame_ok_count   <= '0;
         frame_drop_count <= '0;
         frame_error      <= 1'b0;
      end else begin
         state            <= state_n;
         start_addr       <= start_addr_n;
         len              <= len_n;
         end_seen         <= end_seen_n;
         in_flight        <= rd_en_c;
         skid0            <= skid0_n;
         skid1            <= skid1_n;
         count            <= count_n;
         frame_ok_count   <= ok_n;
         frame_drop_count <= drop_n;
         frame_error      <= frame_error_n;
      end
   end

endmodule
